// File: rtl/rr_channel_scheduler_pkg.sv
// Shared types and constants for the round-robin channel scheduler.
// Selects are 2 bits because the shared channel uses a 4:1 MUX and a 1:4 DEMUX.
package rr_channel_scheduler_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_REQ-1:0] req_t;

  function automatic req_t onehot(input sel_t idx);
    req_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_channel_scheduler_if.sv
// Request/grant bundle between the requesters and the scheduler, plus the
// MUX/DEMUX selects and the channel-valid qualifier.
interface rr_channel_scheduler_if;

  logic [rr_channel_scheduler_pkg::NUM_REQ-1:0] req;
  logic [rr_channel_scheduler_pkg::NUM_REQ-1:0] gnt;
  logic                                         s1;
  logic                                         s0;
  logic                                         ch_valid;

  modport master (output req, input gnt, s1, s0, ch_valid);
  modport slave  (input req, output gnt, s1, s0, ch_valid);

endinterface

// File: rtl/rr_channel_scheduler_pick4.sv
// Combinational round-robin picker: first set request scanning upward from last+1.
// The port that was served last is scanned last, so it has the lowest priority.
module rr_pick4
  import rr_channel_scheduler_pkg::*;
(
  input  req_t req,
  input  sel_t last,
  output sel_t idx,
  output logic any
);

  always_comb begin
    sel_t cand;
    // NOTE: every combinational output is given a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    idx  = '0;
    cand = '0;
    any  = |req;
    // Scan from farthest to nearest so the nearest set request is written last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = sel_t'(int'(last) + k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_channel_scheduler.sv
// Round-robin scheduler for a shared 1-bit channel: grants one of four requesters,
// drives the MUX/DEMUX selects, and forces rotation after MAX_HOLD cycles under contention.
module rr_channel_scheduler
  import rr_channel_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rr_channel_scheduler_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;
  sel_t              last_q,  last_d;
  sel_t              sel_q,   sel_d;
  req_t              gnt_q,   gnt_d;

  sel_t pick_idx;
  logic pick_any;
  logic at_limit;
  logic others;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign at_limit = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  assign others   = |(bus.req & ~gnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // Selects only move together with a new grant, so they hold while idle.
        gnt_d = '0;
        if (pick_any) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          cnt_d   = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (!bus.req[sel_q] || (at_limit && others)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = sel_q;
          cnt_d   = '0;
        end else if (at_limit) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= sel_t'(NUM_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.s1       = sel_q[1];
  assign bus.s0       = sel_q[0];
  assign bus.ch_valid = |gnt_q;

endmodule

// File: tb/tb_rr_channel_scheduler.sv
// Bench for rr_channel_scheduler: three instances (hold limits 4, 2, unlimited) share one
// request vector; an integer-level scheduling model predicts grants and selects each cycle.
module tb_rr_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_channel_scheduler_if bus_a ();
  rr_channel_scheduler_if bus_b ();
  rr_channel_scheduler_if bus_c ();

  assign bus_a.req = req;
  assign bus_b.req = req;
  assign bus_c.req = req;

  rr_channel_scheduler #(.MAX_HOLD(4), .HOLD_W(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  rr_channel_scheduler #(.MAX_HOLD(2), .HOLD_W(4)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  rr_channel_scheduler #(.MAX_HOLD(0), .HOLD_W(4)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Existing 4:1 MUX and 1:4 DEMUX, steered by instance B's selects.
  logic [3:0] datain  = 4'b1010;
  logic       data_in = 1'b1;
  logic       data_out;
  logic [3:0] d_out;

  always_comb begin
    data_out = datain[{bus_b.s1, bus_b.s0}];
    d_out    = 4'b0000;
    d_out[{bus_b.s1, bus_b.s0}] = data_in & bus_b.ch_valid;
  end

  // Scheduling model: which port owns the channel, for how long, and who went last.
  typedef struct {
    bit busy;
    int cur;
    int cnt;
    int last;
    int sel;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.cur = 0; m.cnt = 0; m.last = 3; m.sel = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit r, logic [3:0] q, int max_hold);
    mdl_t n = m;
    bit   expired;
    if (r) return mdl_reset();
    if (!m.busy) begin
      for (int k = 1; k <= 4; k++) begin
        int p = (m.last + k) % 4;
        if (q[p] && !n.busy) begin
          n.busy = 1; n.cur = p; n.sel = p; n.cnt = 1;
        end
      end
    end else begin
      expired = (max_hold != 0) && (m.cnt == max_hold);
      if (!q[m.cur] || (expired && (q & ~(4'b0001 << m.cur)) != 0)) begin
        n.busy = 0; n.last = m.cur;
      end else if (expired) begin
        n.cnt = 1;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] mdl_gnt(mdl_t m);
    return m.busy ? (4'b0001 << m.cur) : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string nm, input mdl_t m, input logic [3:0] g,
                            input logic s1, input logic s0, input logic cv);
    check({nm, "_gnt"}, 32'(g), 32'(mdl_gnt(m)));
    check({nm, "_sel"}, 32'({s1, s0}), 32'(m.sel));
    check({nm, "_valid"}, 32'(cv), 32'(m.busy));
  endtask

  task automatic check_all();
    check_inst("a", ma, bus_a.gnt, bus_a.s1, bus_a.s0, bus_a.ch_valid);
    check_inst("b", mb, bus_b.gnt, bus_b.s1, bus_b.s0, bus_b.ch_valid);
    check_inst("c", mc, bus_c.gnt, bus_c.s1, bus_c.s0, bus_c.ch_valid);
    if (mb.busy) begin
      check("dp_mux", 32'(data_out), 32'(datain[mb.sel]));
      check("dp_demux", 32'(d_out), 32'(4'b0001 << mb.sel));
    end
  endtask

  // Apply inputs, clock once, advance the models, then compare on the falling edge.
  task automatic run_cycle(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    ma = mdl_step(ma, r, q, 4);
    mb = mdl_step(mb, r, q, 2);
    mc = mdl_step(mc, r, q, 0);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit         reached;
    logic [3:0] rq;

    rst = 1'b1;
    req = 4'b0000;
    ma  = mdl_reset();
    mb  = mdl_reset();
    mc  = mdl_reset();

    // Reset held with all requests up, then port 0 wins first.
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b1, 4'b1111);
      check("t1_rst_gnt", 32'(bus_a.gnt), 32'h0);
      check("t1_rst_sel", 32'({bus_a.s1, bus_a.s0}), 32'h0);
    end
    run_cycle(1'b0, 4'b1111);
    check("t1_first_gnt", 32'(bus_a.gnt), 32'h1);

    // Full contention: rotation with hold limit and one-cycle turnaround gaps.
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 4'b1111);
    check("t2_wrap_gnt", 32'(bus_a.gnt), 32'h1);

    // Single requester keeps the channel across hold expiries with no gap.
    run_cycle(1'b1, 4'b0100);
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 4'b0100);
      check("t3_hold_gnt", 32'(bus_a.gnt), 32'h4);
      check("t3_hold_sel", 32'({bus_a.s1, bus_a.s0}), 32'h2);
    end

    // Request drop during the second grant cycle releases early.
    run_cycle(1'b1, 4'b1010);
    run_cycle(1'b0, 4'b1010);
    check("t4_c1", 32'(bus_a.gnt), 32'h2);
    run_cycle(1'b0, 4'b1010);
    check("t4_c2", 32'(bus_a.gnt), 32'h2);
    run_cycle(1'b0, 4'b1000);
    check("t4_gap", 32'(bus_a.gnt), 32'h0);
    run_cycle(1'b0, 4'b1000);
    check("t4_next", 32'(bus_a.gnt), 32'h8);
    check("t4_sel", 32'({bus_a.s1, bus_a.s0}), 32'h3);

    // Reset in the middle of port 2's grant restores port-0-first priority.
    run_cycle(1'b1, 4'b1111);
    reached = 1'b0;
    for (int i = 0; i < 24 && !reached; i++) begin
      run_cycle(1'b0, 4'b1111);
      if (bus_a.gnt == 4'b0100) reached = 1'b1;
    end
    check("t5_reach", 32'(reached), 32'h1);
    run_cycle(1'b1, 4'b1111);
    check("t5_rst_gnt", 32'(bus_a.gnt), 32'h0);
    run_cycle(1'b0, 4'b1111);
    check("t5_next_gnt", 32'(bus_a.gnt), 32'h1);

    // Random traffic: requests persist for random stretches, with rare resets.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rq = 4'($urandom);
      run_cycle(($urandom_range(63) == 0), rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
